eth_rx_mem_writer: RTL and testbench

Bus-initiator block that moves received Ethernet frames from the MAC byte stream into shared memory over the 32-bit native memory interface (valid/ready/addr/wdata/wstrb). It packs bytes little-endian into words and writes them to a software-supplied buffer. It then writes a one-word length header at the buffer base and pulses `done`. It sits between the MAC receive path and the memory arbiter, on the same port type that the on-chip memory responder serves.

---
 rtl/eth_dma_pkg.sv | 46 ++++
 rtl/eth_rx_mem_writer_packer.sv | 59 +++++
 rtl/eth_rx_mem_writer.sv | 215 +++++++++++++++++++++
 tb/tb_eth_rx_mem_writer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_dma_pkg.sv
// -----------------------------------------------------------------------------
// eth_dma_pkg
// Shared types and constants for the Ethernet receive-to-memory writer.
//   rx_wr_state_t : writer FSM states
//   WSTRB_WORD    : full-word byte strobe
//   HDR_TRUNC_BIT : bit position of the truncated flag in the length header
//   HDR_OFFSET    : header word offset from the buffer base
//   DATA_OFFSET   : first payload word offset from the buffer base
// Helpers build the header word and single-lane strobe/mask values.
// -----------------------------------------------------------------------------
package eth_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WR_WORD = 3'd2,
    ST_WR_BYTE = 3'd3,
    ST_WR_HDR  = 3'd4,
    ST_GAP     = 3'd5,
    ST_DONE    = 3'd6
  } rx_wr_state_t;

  localparam logic [3:0]  WSTRB_WORD    = 4'hF;
  localparam int          HDR_TRUNC_BIT = 16;
  localparam logic [31:0] HDR_OFFSET    = 32'd0;
  localparam logic [31:0] DATA_OFFSET   = 32'd4;

  // Length header: {15'b0, truncated, count[15:0]}
  function automatic logic [31:0] hdr_word(input logic trunc, input logic [15:0] count);
    logic [31:0] w;
    w = {16'd0, count};
    w[HDR_TRUNC_BIT] = trunc;
    return w;
  endfunction

  // One-hot strobe for a single byte lane
  function automatic logic [3:0] lane_strobe(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Data mask keeping only one byte lane
  function automatic logic [31:0] lane_mask(input logic [1:0] lane);
    return 32'h0000_00FF << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/eth_rx_mem_writer_packer.sv
// -----------------------------------------------------------------------------
// eth_byte_packer
// Little-endian byte-to-word assembly with a 2-bit lane counter.
//   clk, resetn    : clock, synchronous active-low reset
//   clr_i          : restart packing at lane 0 (new frame)
//   push_i         : store data_i into the current lane this cycle
//   data_i[7:0]    : byte to store
//   word_o[31:0]   : assembled word (registered)
//   word_next_o    : assembled word including this cycle's push
//   lane_count_o   : next lane to fill = number of bytes held in word_o
//   flush_o        : this push fills lane 3, completing a word
// -----------------------------------------------------------------------------
module eth_byte_packer
  import eth_dma_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic [31:0] word_next_o,
  output logic [1:0]  lane_count_o,
  output logic        flush_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;

  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    if (clr_i) begin
      word_d = 32'd0;
      lane_d = 2'd0;
    end else if (push_i) begin
      word_d[{lane_q, 3'b000} +: 8] = data_i;
      lane_d = lane_q + 2'd1;
    end else begin
      word_d = word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_q <= 32'd0;
      lane_q <= 2'd0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
    end
  end

  assign word_o       = word_q;
  assign word_next_o  = word_d;
  assign lane_count_o = lane_q;
  assign flush_o      = push_i & ~clr_i & (lane_q == 2'd3);

endmodule

// File: rtl/eth_rx_mem_writer.sv
// -----------------------------------------------------------------------------
// eth_rx_mem_writer
// Moves one received Ethernet frame from the MAC byte stream into a memory
// buffer over the native valid/ready memory port, then writes a length header
// at the buffer base and pulses done.
//   clk, resetn            : clock, synchronous active-low reset
//   s_data/s_valid/s_last  : receive byte stream; s_ready accepts a byte
//   start, buf_addr        : arm for one frame at buf_addr (word aligned)
//   busy, done             : frame in progress / one-cycle completion pulse
//   length, truncated      : stored byte count and overflow flag
//   mem_*                  : write-only memory initiator (mem_rdata unused)
// -----------------------------------------------------------------------------
module eth_rx_mem_writer
  import eth_dma_pkg::*;
#(
  parameter int MAX_LEN = 1536
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        start,
  input  logic [31:0] buf_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] length,
  output logic        truncated,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

  rx_wr_state_t state_q, after_gap_q;
  logic [31:0]  base_q, ptr_q;
  logic [15:0]  count_q, length_q;
  logic [1:0]   byte_idx_q;
  logic         last_q;
  logic         s_ready_q, busy_q, done_q, truncated_q;
  logic         mem_valid_q;
  logic [31:0]  mem_addr_q, mem_wdata_q;
  logic [3:0]   mem_wstrb_q;

  logic         full_s, push_s, clr_s, flush_s;
  logic [31:0]  word_s, word_next_s;
  logic [1:0]   lane_count_s;
  logic         unused_s;

  // Once MAX_LEN bytes are stored, further bytes are accepted but dropped
  assign full_s = (count_q == MAX_LEN_C);
  assign push_s = (state_q == ST_COLLECT) & s_valid & ~full_s;
  assign clr_s  = (state_q == ST_IDLE) & start;

  eth_byte_packer u_packer (
    .clk          (clk),
    .resetn       (resetn),
    .clr_i        (clr_s),
    .push_i       (push_s),
    .data_i       (s_data),
    .word_o       (word_s),
    .word_next_o  (word_next_s),
    .lane_count_o (lane_count_s),
    .flush_o      (flush_s)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      after_gap_q <= ST_IDLE;
      base_q      <= 32'd0;
      ptr_q       <= 32'd0;
      count_q     <= 16'd0;
      length_q    <= 16'd0;
      byte_idx_q  <= 2'd0;
      last_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      truncated_q <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q      <= {buf_addr[31:2], 2'b00};
            ptr_q       <= {buf_addr[31:2], 2'b00} + DATA_OFFSET;
            count_q     <= 16'd0;
            truncated_q <= 1'b0;
            busy_q      <= 1'b1;
            s_ready_q   <= 1'b1;
            state_q     <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (s_valid) begin
            if (full_s) begin
              truncated_q <= 1'b1;
              if (s_last) begin
                s_ready_q   <= 1'b0;
                mem_valid_q <= 1'b1;
                mem_addr_q  <= base_q + HDR_OFFSET;
                mem_wdata_q <= hdr_word(1'b1, count_q);
                mem_wstrb_q <= WSTRB_WORD;
                state_q     <= ST_WR_HDR;
              end
            end else begin
              count_q <= count_q + 16'd1;
              if (flush_s) begin
                s_ready_q   <= 1'b0;
                mem_valid_q <= 1'b1;
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= word_next_s;
                mem_wstrb_q <= WSTRB_WORD;
                last_q      <= s_last;
                state_q     <= ST_WR_WORD;
              end else if (s_last) begin
                // Residual 1-3 bytes go out one lane at a time
                s_ready_q   <= 1'b0;
                byte_idx_q  <= 2'd0;
                mem_valid_q <= 1'b1;
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= word_next_s & lane_mask(2'd0);
                mem_wstrb_q <= lane_strobe(2'd0);
                state_q     <= ST_WR_BYTE;
              end
            end
          end
        end
        ST_WR_WORD: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            ptr_q       <= ptr_q + 32'd4;
            after_gap_q <= last_q ? ST_WR_HDR : ST_COLLECT;
            state_q     <= ST_GAP;
          end
        end
        ST_WR_BYTE: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            byte_idx_q  <= byte_idx_q + 2'd1;
            after_gap_q <= ((byte_idx_q + 2'd1) == lane_count_s) ? ST_WR_HDR : ST_WR_BYTE;
            state_q     <= ST_GAP;
          end
        end
        ST_WR_HDR: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            after_gap_q <= ST_DONE;
            state_q     <= ST_GAP;
          end
        end
        // One dead cycle swallows the responder's trailing ready
        ST_GAP: begin
          state_q <= after_gap_q;
          case (after_gap_q)
            ST_COLLECT: s_ready_q <= 1'b1;
            ST_WR_BYTE: begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= ptr_q;
              mem_wdata_q <= word_s & lane_mask(byte_idx_q);
              mem_wstrb_q <= lane_strobe(byte_idx_q);
            end
            ST_WR_HDR: begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= base_q + HDR_OFFSET;
              mem_wdata_q <= hdr_word(truncated_q, count_q);
              mem_wstrb_q <= WSTRB_WORD;
            end
            ST_DONE: begin
              done_q   <= 1'b1;
              length_q <= count_q;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_valid_q <= 1'b0;
          s_ready_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign length    = length_q;
  assign truncated = truncated_q;
  assign mem_valid = mem_valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  // Read data and buffer address low bits have no function in a write-only initiator
  assign unused_s = ^{mem_rdata, buf_addr[1:0]};

endmodule

// File: tb/tb_eth_rx_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_mem_writer
// Directed bench: byte source, configurable memory responder that logs writes,
// hand-computed expected writes, headers, lengths and flags.
// -----------------------------------------------------------------------------
module tb_eth_rx_mem_writer;

  localparam int MAX_LEN = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        start = 1'b0;
  logic [31:0] buf_addr = 32'd0;
  logic        busy, done, truncated;
  logic [15:0] length;
  logic        mem_valid, mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'd0;

  eth_rx_mem_writer #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .start     (start),
    .buf_addr  (buf_addr),
    .busy      (busy),
    .done      (done),
    .length    (length),
    .truncated (truncated),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Free-running cycle count, read at negedges
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder configuration and write log
  int          wait_cfg  = 0;
  int          hold_from = 1000;
  bit          stale_cfg = 1'b0;
  int          wr_n = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  int          wr_cyc  [16];

  // Memory responder: acts at negedges, ready is sampled at the following posedge
  initial begin : responder
    int          wait_cnt;
    bit          hs_armed;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_strb;
    wait_cnt = 0;
    hs_armed = 1'b0;
    cap_addr = 32'd0;
    cap_data = 32'd0;
    cap_strb = 4'd0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        mem_ready = 1'b0;
        hs_armed  = 1'b0;
        wait_cnt  = 0;
      end else if (hs_armed) begin
        hs_armed = 1'b0;
        check_eq("gap_valid_low", 32'(mem_valid), 32'd0);
        mem_ready = stale_cfg;
        wait_cnt  = 0;
      end else if (mem_valid === 1'b1) begin
        if (wait_cnt == 0) begin
          cap_addr = mem_addr;
          cap_data = mem_wdata;
          cap_strb = mem_wstrb;
        end else begin
          check_eq("stall_addr", mem_addr, cap_addr);
          check_eq("stall_wdata", mem_wdata, cap_data);
          check_eq("stall_wstrb", 32'(mem_wstrb), 32'(cap_strb));
          check_eq("stall_s_ready", 32'(s_ready), 32'd0);
        end
        if (wait_cnt >= wait_cfg && wr_n < hold_from) begin
          mem_ready = 1'b1;
          if (wr_n < 16) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            wr_strb[wr_n] = mem_wstrb;
            wr_cyc[wr_n]  = cyc;
          end
          wr_n++;
          hs_armed = 1'b1;
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  logic [7:0] frame_b [16];
  int         acc_cnt;

  task automatic clear_log();
    for (int i = 0; i < 16; i++) begin
      wr_addr[i] = 32'hDEAD_BEEF;
      wr_data[i] = 32'hDEAD_BEEF;
      wr_strb[i] = 4'd0;
      wr_cyc[i]  = 0;
    end
    wr_n = 0;
  endtask

  task automatic start_frame(input logic [31:0] base);
    start    = 1'b1;
    buf_addr = base;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_frame(input int n);
    int tmo;
    acc_cnt = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = frame_b[i];
      s_last  = (i == n - 1);
      tmo = 0;
      while (s_ready !== 1'b1 && tmo < 200) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 200) begin
        check_eq("s_ready_timeout", 32'(tmo), 32'd0);
        break;
      end
      @(negedge clk);
      acc_cnt++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_wr(input string pfx, input int idx, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] mask, input logic [3:0] strb);
    check_eq($sformatf("%s_w%0d_addr", pfx, idx), wr_addr[idx], addr);
    check_eq($sformatf("%s_w%0d_data", pfx, idx), wr_data[idx] & mask, data);
    check_eq($sformatf("%s_w%0d_strb", pfx, idx), 32'(wr_strb[idx]), 32'(strb));
  endtask

  task automatic wait_done(input string pfx, input int exp_len, input bit exp_trunc);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq({pfx, "_done_seen"}, 32'(done), 32'd1);
    if (done === 1'b1) begin
      check_eq({pfx, "_length"}, 32'(length), 32'(exp_len));
      check_eq({pfx, "_truncated"}, 32'(truncated), 32'(exp_trunc));
      check_eq({pfx, "_done_latency"}, 32'(cyc - wr_cyc[(wr_n - 1) & 15]), 32'd2);
      @(negedge clk);
      check_eq({pfx, "_done_pulse"}, 32'(done), 32'd0);
      check_eq({pfx, "_busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    clear_log();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_length", 32'(length), 32'd0);
    check_eq("rst_truncated", 32'(truncated), 32'd0);
    check_eq("mem_instr", 32'(mem_instr), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: eight bytes 01..08 at 0x100
    clear_log();
    for (int i = 0; i < 8; i++) frame_b[i] = 8'(i + 1);
    start_frame(32'h0000_0100);
    check_eq("t1_busy", 32'(busy), 32'd1);
    send_frame(8);
    wait_done("t1", 8, 1'b0);
    check_eq("t1_wr_n", 32'(wr_n), 32'd3);
    check_wr("t1", 0, 32'h104, 32'h0403_0201, 32'hFFFF_FFFF, 4'hF);
    check_wr("t1", 1, 32'h108, 32'h0807_0605, 32'hFFFF_FFFF, 4'hF);
    check_wr("t1", 2, 32'h100, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF);

    // 2: six bytes AA..FF at 0x202 (aligned down to 0x200)
    clear_log();
    frame_b[0] = 8'hAA; frame_b[1] = 8'hBB; frame_b[2] = 8'hCC;
    frame_b[3] = 8'hDD; frame_b[4] = 8'hEE; frame_b[5] = 8'hFF;
    start_frame(32'h0000_0202);
    send_frame(6);
    wait_done("t2", 6, 1'b0);
    check_eq("t2_wr_n", 32'(wr_n), 32'd4);
    check_wr("t2", 0, 32'h204, 32'hDDCC_BBAA, 32'hFFFF_FFFF, 4'hF);
    check_wr("t2", 1, 32'h208, 32'h0000_00EE, 32'h0000_00FF, 4'h1);
    check_wr("t2", 2, 32'h208, 32'h0000_FF00, 32'h0000_FF00, 4'h2);
    check_wr("t2", 3, 32'h200, 32'h0000_0006, 32'hFFFF_FFFF, 4'hF);

    // 3: eleven bytes with an 8-byte limit
    clear_log();
    for (int i = 0; i < 11; i++) frame_b[i] = 8'(8'h10 + i);
    start_frame(32'h0000_0300);
    send_frame(11);
    check_eq("t3_accepted", 32'(acc_cnt), 32'd11);
    wait_done("t3", 8, 1'b1);
    check_eq("t3_wr_n", 32'(wr_n), 32'd3);
    check_wr("t3", 0, 32'h304, 32'h1312_1110, 32'hFFFF_FFFF, 4'hF);
    check_wr("t3", 1, 32'h308, 32'h1716_1514, 32'hFFFF_FFFF, 4'hF);
    check_wr("t3", 2, 32'h300, 32'h0001_0008, 32'hFFFF_FFFF, 4'hF);

    // 4: responder stalls 5 cycles per write
    clear_log();
    wait_cfg = 5;
    for (int i = 0; i < 4; i++) frame_b[i] = 8'(8'h21 + i);
    start_frame(32'h0000_0400);
    send_frame(4);
    wait_done("t4", 4, 1'b0);
    wait_cfg = 0;
    check_eq("t4_wr_n", 32'(wr_n), 32'd2);
    check_wr("t4", 0, 32'h404, 32'h2423_2221, 32'hFFFF_FFFF, 4'hF);
    check_wr("t4", 1, 32'h400, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF);

    // 5: responder keeps ready high one cycle past each handshake
    clear_log();
    stale_cfg = 1'b1;
    for (int i = 0; i < 5; i++) frame_b[i] = 8'(8'h31 + i);
    start_frame(32'h0000_0500);
    send_frame(5);
    wait_done("t5", 5, 1'b0);
    repeat (3) @(negedge clk);
    stale_cfg = 1'b0;
    check_eq("t5_wr_n", 32'(wr_n), 32'd3);
    check_wr("t5", 0, 32'h504, 32'h3433_3231, 32'hFFFF_FFFF, 4'hF);
    check_wr("t5", 1, 32'h508, 32'h0000_0035, 32'h0000_00FF, 4'h1);
    check_wr("t5", 2, 32'h500, 32'h0000_0005, 32'hFFFF_FFFF, 4'hF);

    // 6: reset while the second word request is pending
    clear_log();
    hold_from = 1;
    for (int i = 0; i < 8; i++) frame_b[i] = 8'(8'h41 + i);
    start_frame(32'h0000_0600);
    send_frame(8);
    check_eq("t6_second_req", 32'(mem_valid), 32'd1);
    check_eq("t6_wr_n_before", 32'(wr_n), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    hold_from = 1000;
    repeat (6) @(negedge clk);
    check_eq("t6_no_header", 32'(wr_n), 32'd1);
    check_eq("t6_idle_valid", 32'(mem_valid), 32'd0);

    clear_log();
    for (int i = 0; i < 4; i++) frame_b[i] = 8'(8'h51 + i);
    start_frame(32'h0000_0700);
    send_frame(4);
    wait_done("t6b", 4, 1'b0);
    check_eq("t6b_wr_n", 32'(wr_n), 32'd2);
    check_wr("t6b", 0, 32'h704, 32'h5453_5251, 32'hFFFF_FFFF, 4'hF);
    check_wr("t6b", 1, 32'h700, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
